// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use hazard detection and flush/stall priority.
// Define IDEX_PERF_CNT_EN to add saturating stall/bubble performance counters.
module id_ex_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [DATA_W-1:0]  id_movsrc,
    input  logic [DATA_W-1:0]  id_rs2_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [REG_AW-1:0]  id_rs1_addr,
    input  logic [REG_AW-1:0]  id_rs2_addr,
    input  logic [REG_AW-1:0]  id_rd_addr,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_reg_we,
    input  logic               id_mem_re,
    input  logic               id_mem_we,
    input  logic               stall,
    input  logic               flush,
    output logic               load_use_stall,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [DATA_W-1:0]  ex_movsrc,
    output logic [DATA_W-1:0]  ex_rs2_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_AW-1:0]  ex_rd_addr,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_reg_we,
    output logic               ex_mem_re,
    output logic               ex_mem_we
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_bubble_cnt
`endif
);
    logic bubble;

    assign load_use_stall = ex_valid & ex_mem_re & (ex_rd_addr != '0) & id_valid &
                            ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));
    // flush overrides a downstream hold; a load-use bubble waits for the hold to drop
    assign bubble = flush | (~stall & load_use_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_movsrc   <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd_addr  <= '0;
            ex_alu_op   <= '0;
            ex_reg_we   <= 1'b0;
            ex_mem_re   <= 1'b0;
            ex_mem_we   <= 1'b0;
        end else if (!stall) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_movsrc   <= id_movsrc;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rd_addr  <= id_rd_addr;
            ex_alu_op   <= id_alu_op;
            ex_reg_we   <= id_reg_we;
            ex_mem_re   <= id_mem_re;
            ex_mem_we   <= id_mem_we;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (stall && !flush && !(&perf_stall_cnt))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (bubble && !(&perf_bubble_cnt))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: scoreboard bench for id_ex_reg; directed vectors, monitor pops expectations per edge.
module tb_id_ex_reg;
    typedef struct packed {
        logic        v;
        logic [31:0] pc, mov, rs2, imm;
        logic [4:0]  rd;
        logic [5:0]  op;
        logic        we, re, mwe;
    } ex_t;
    typedef struct packed {
        logic lus;
        ex_t  ex;
    } exp_t;
    localparam int CAP = 0, BUB = 1, HOLD = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic id_valid, id_reg_we, id_mem_re, id_mem_we, stall, flush, load_use_stall;
    logic [31:0] id_pc, id_movsrc, id_rs2_data, id_imm;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [5:0] id_alu_op;
    logic ex_valid, ex_reg_we, ex_mem_re, ex_mem_we;
    logic [31:0] ex_pc, ex_movsrc, ex_rs2_data, ex_imm;
    logic [4:0] ex_rd_addr;
    logic [5:0] ex_alu_op;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

    exp_t q[$];
    ex_t model = '0;
    int checks = 0, passed = 0, step = 0;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_movsrc(id_movsrc),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_alu_op(id_alu_op),
        .id_reg_we(id_reg_we), .id_mem_re(id_mem_re), .id_mem_we(id_mem_we),
        .stall(stall), .flush(flush), .load_use_stall(load_use_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_movsrc(ex_movsrc), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr), .ex_alu_op(ex_alu_op),
        .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we)
`ifdef IDEX_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic ex_t actual();
        return '{ex_valid, ex_pc, ex_movsrc, ex_rs2_data, ex_imm, ex_rd_addr, ex_alu_op,
                 ex_reg_we, ex_mem_re, ex_mem_we};
    endfunction

    task automatic chk(input string name, input logic [143:0] got, input logic [143:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s step %0d: got %h want %h", name, step, got, want);
    endtask

    task automatic setid(input logic v, input logic [31:0] pc, mov, input logic [4:0] rs1, rs2, rd,
                         input logic we, re, mwe);
        id_valid = v; id_pc = pc; id_movsrc = mov;
        id_rs2_data = pc ^ 32'hA5A5_0000; id_imm = pc + 32'h40; id_alu_op = pc[7:2];
        id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_reg_we = we; id_mem_re = re; id_mem_we = mwe;
    endtask

    // called at a falling edge: applies controls, queues the outcome of the next rising edge
    task automatic go(input logic st, fl, lus, input int kind);
        stall = st; flush = fl;
        if (kind == CAP)
            model = '{id_valid, id_pc, id_movsrc, id_rs2_data, id_imm, id_rd_addr, id_alu_op,
                      id_reg_we, id_mem_re, id_mem_we};
        else if (kind == BUB)
            model = '0;
        q.push_back('{lus, model});
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                step++;
                chk("load_use_stall", {143'b0, load_use_stall}, {143'b0, e.lus});
                @(posedge clk);
                #1;
                chk("ex_outputs", {1'b0, actual()}, {1'b0, e.ex});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        stall = 0; flush = 0;
        setid(1, 32'h1, 32'h2, 0, 0, 0, 1, 1, 1);
        #2;
        chk("reset_ex", {1'b0, actual()}, 144'b0);
        chk("reset_lus", {143'b0, load_use_stall}, 144'b0);
        @(negedge clk);
        rst = 0;
        setid(1, 32'h100, 32'hDEAD_BEEF, 1, 2, 3, 1, 0, 0); go(0, 0, 0, CAP);
        setid(1, 32'h104, 32'h11, 6, 7, 5, 1, 1, 0);        go(0, 0, 0, CAP);
        setid(1, 32'h108, 32'h22, 9, 5, 8, 1, 0, 0);        go(0, 0, 1, BUB);
        go(0, 0, 0, CAP);
        setid(1, 32'h10C, 32'h33, 4, 4, 0, 0, 1, 0);        go(0, 0, 0, CAP);
        setid(1, 32'h110, 32'h44, 0, 0, 9, 1, 0, 0);        go(0, 0, 0, CAP);
        for (int i = 0; i < 3; i++) begin
            setid(1, 32'h200 + 32'(4 * i), 32'h50 + 32'(i), 10, 11, 5'(10 + i), 1, 0, 0);
            go(1, 0, 0, HOLD);
        end
        setid(1, 32'h120, 32'h66, 1, 2, 12, 1, 1, 0);       go(0, 0, 0, CAP);
        setid(1, 32'h124, 32'h77, 12, 3, 13, 0, 0, 1);
        go(1, 0, 1, HOLD); go(1, 0, 1, HOLD); go(0, 0, 1, BUB); go(0, 0, 0, CAP);
        setid(1, 32'h128, 32'h88, 1, 2, 14, 1, 0, 1);       go(1, 1, 0, BUB);
        setid(1, 32'h130, 32'h99, 1, 2, 7, 1, 1, 0);        go(0, 0, 0, CAP);
        setid(0, 32'h134, 32'hAA, 7, 0, 15, 1, 0, 0);       go(0, 0, 0, CAP);
        setid(1, 32'h138, 32'h1234, 1, 2, 6, 1, 0, 0);      go(0, 0, 0, CAP);
        #2;
        rst = 1;
        #1;
        chk("async_reset_ex", {1'b0, actual()}, 144'b0);
        chk("async_reset_lus", {143'b0, load_use_stall}, 144'b0);
        @(posedge clk);
        #1;
        chk("reset_hold_ex", {1'b0, actual()}, 144'b0);
        @(negedge clk);
        rst = 0;
        model = '0;
        setid(1, 32'h13C, 32'hBB, 1, 2, 4, 1, 0, 0);        go(0, 0, 0, CAP);
`ifdef IDEX_PERF_CNT_EN
        for (int i = 0; i < 4; i++) go(1, 0, 0, HOLD);
        go(0, 1, 0, BUB);
        setid(1, 32'h140, 32'hCC, 1, 2, 9, 1, 1, 0);        go(0, 0, 0, CAP);
        setid(1, 32'h144, 32'hDD, 9, 2, 10, 1, 0, 0);       go(0, 0, 1, BUB);
        chk("perf_stall_cnt", {112'b0, perf_stall_cnt}, {112'b0, 32'd4});
        chk("perf_bubble_cnt", {112'b0, perf_bubble_cnt}, {112'b0, 32'd2});
        force dut.perf_stall_cnt = 32'hFFFF_FFFF;
        force dut.perf_bubble_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.perf_stall_cnt;
        release dut.perf_bubble_cnt;
        go(1, 0, 0, HOLD);
        go(0, 1, 0, BUB);
        chk("perf_stall_sat", {112'b0, perf_stall_cnt}, {112'b0, 32'hFFFF_FFFF});
        chk("perf_bubble_sat", {112'b0, perf_bubble_cnt}, {112'b0, 32'hFFFF_FFFF});
`endif
        #20;
        chk("queue_drained", 144'(q.size()), 144'b0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
